// File: rtl/bipolar_stream_gen.sv
// bipolar_stream_gen: two's-complement value to 2^WIDTH-bit bipolar unary stream, bit-reversed counter order
module bipolar_stream_gen #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_bit,
  output logic             out_last
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_s, r_u, w_s_nxt, w_u_nxt, w_rev;
  logic             w_in_hs, w_beat;
  for (genvar i = 0; i < WIDTH; i++) begin : g_rev
    assign w_rev[i] = r_s[WIDTH-1-i];
  end
  assign out_valid = r_state == RUN;
  assign out_last  = out_valid & (r_s == {WIDTH{1'b1}});
  assign out_bit   = out_valid & (w_rev < r_u);
  // a value may be accepted on the final beat so streams run back-to-back
  assign in_ready  = !out_valid | (out_last & out_ready);
  assign w_in_hs   = in_valid & in_ready;
  assign w_beat    = out_valid & out_ready;
  always_comb begin
    w_state_nxt = r_state;
    w_s_nxt     = r_s;
    w_u_nxt     = r_u;
    if (w_in_hs) begin
      w_state_nxt = RUN;
      w_s_nxt     = '0;
      w_u_nxt     = {~in_data[WIDTH-1], in_data[WIDTH-2:0]};
    end else if (w_beat) begin
      w_state_nxt = out_last ? IDLE : RUN;
      w_s_nxt     = out_last ? '0 : r_s + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_s     <= '0;
      r_u     <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_s     <= w_s_nxt;
      r_u     <= w_u_nxt;
    end
  end
endmodule

// File: tb/tb_bipolar_stream_gen.sv
// tb_bipolar_stream_gen: scoreboard bench for bipolar_stream_gen (WIDTH=8)
module tb_bipolar_stream_gen;
  logic       clk = 0;
  logic       rst_n = 0;
  logic       in_valid = 0;
  logic       in_ready;
  logic [7:0] in_data = 0;
  logic       out_valid;
  logic       out_ready = 1;
  logic       out_bit;
  logic       out_last;
  int n_checks = 0;
  int n_fail = 0;
  bit exp_q[$];
  int u_q[$];
  int beat_idx = 0;
  int ones = 0;
  int cur_u = 0;
  bit stall_prev = 0;
  bit prev_bit, prev_last;
  bipolar_stream_gen #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_bit(out_bit), .out_last(out_last)
  );
  always #5 clk = ~clk;
  task automatic check(string tag, int got, int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [7:0] brev(logic [7:0] x);
    logic [7:0] y;
    for (int i = 0; i < 8; i++) y[i] = x[7-i];
    return y;
  endfunction
  // monitor: scores beats first, then queues the stream of any value accepted this cycle
  always @(negedge clk) begin
    if (rst_n) begin
      if (stall_prev && out_valid) begin
        check("hold_bit", out_bit, prev_bit);
        check("hold_last", out_last, prev_last);
      end
      stall_prev = out_valid && !out_ready;
      prev_bit = out_bit;
      prev_last = out_last;
      if (out_valid && out_ready) begin
        if (beat_idx == 0 && u_q.size() != 0) cur_u = u_q.pop_front();
        if (exp_q.size() == 0) check("unexpected_beat", 1, 0);
        else check("bit", out_bit, int'(exp_q.pop_front()));
        check("last", out_last, int'(beat_idx == 255));
        ones += int'(out_bit);
        beat_idx++;
        if (cur_u == 192 && beat_idx % 4 == 0) check("prefix", ones, 3 * beat_idx / 4);
        if (beat_idx == 256) begin
          check("ones", ones, cur_u);
          beat_idx = 0;
          ones = 0;
        end
      end
      if (in_valid && in_ready) begin
        int u;
        u = int'(in_data) ^ 128;
        u_q.push_back(u);
        for (int k = 0; k < 256; k++) exp_q.push_back(int'(brev(8'(k))) < u);
      end
    end
  end
  task automatic send(logic [7:0] v);
    int n = 0;
    in_valid = 1;
    in_data = v;
    @(negedge clk);
    while (!in_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("send_timeout", 0, 1);
    @(posedge clk);
    #1 in_valid = 0;
    in_data = $urandom;
  endtask
  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 3000) begin
      @(posedge clk);
      #1 n++;
    end
    if (n >= 3000) check("drain_timeout", n, 0);
    check("idle_ready", in_ready, 1);
    check("idle_valid", out_valid, 0);
  endtask
  task automatic wait_beat(int b);
    int n = 0;
    while (beat_idx != b && n < 3000) begin
      @(posedge clk);
      #1 n++;
    end
    if (n >= 3000) check("beat_timeout", beat_idx, b);
  endtask
  task automatic stall_at(int b, int len);
    wait_beat(b);
    out_ready = 0;
    repeat (len) @(posedge clk);
    #1 out_ready = 1;
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", out_valid, 0);
    check("rst_bit", out_bit, 0);
    check("rst_last", out_last, 0);
    check("rst_ready", in_ready, 1);
    rst_n = 1;
    foreach (u_q[i]) check("stale_u", u_q[i], -1);
    send(8'h00);
    drain();
    send(8'h80);
    drain();
    send(8'h7F);
    drain();
    send(8'h40);
    drain();
    repeat (6) begin
      send(8'($urandom));
      drain();
    end
    send(8'hC3);
    stall_at(37, 5);
    stall_at(255, 1);
    drain();
    send(8'h11);
    in_valid = 1;
    in_data = 8'hE0;
    begin
      int n = 0;
      @(negedge clk);
      while (!in_ready && n < 2000) begin
        @(negedge clk);
        n++;
      end
      check("b2b_last", out_last, 1);
      check("b2b_ready", in_ready, 1);
    end
    @(posedge clk);
    #1 in_valid = 0;
    repeat (256) begin
      @(negedge clk);
      check("b2b_valid", out_valid, 1);
    end
    drain();
    send(8'h25);
    wait_beat(100);
    rst_n = 0;
    @(posedge clk);
    #1 rst_n = 1;
    exp_q.delete();
    u_q.delete();
    beat_idx = 0;
    ones = 0;
    stall_prev = 0;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_ready", in_ready, 1);
    check("mid_rst_bit", out_bit, 0);
    @(posedge clk);
    #1 check("mid_rst_stays_idle", out_valid, 0);
    send(8'h9A);
    drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
